// File: rtl/counter_datapath.sv
// Datapath partner of the up/down counter FSM: count register, push-button conditioning, limit flags.
// Define DEBOUNCE_EN to insert a DB_CYCLES stability filter between each synchronizer and edge detector.
module counter_datapath #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 9,
  parameter int MIN_VAL   = 0,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic             ld,
  input  logic             clr,
  input  logic             s,
  output logic             U,
  output logic             D,
  output logic             CM,
  output logic             Cm,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  // Reject parameter sets for which the saturation guards or the debouncer cannot work.
  if ((MIN_VAL < 0) || (MIN_VAL >= MAX_VAL) || (MAX_VAL > (2**WIDTH) - 1) || (DB_CYCLES < 2))
  begin : g_bad_params
    $error("counter_datapath: illegal parameter set");
  end

  // Bit 0 carries the up button, bit 1 the down button; the two paths never interact.
  logic [1:0]       btn_raw_s;
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       lvl_s;
  logic [1:0]       prev_q;
  logic [1:0]       pulse_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign btn_raw_s = {btn_dn, btn_up};

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= btn_raw_s;
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int             CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

  logic [1:0][CW-1:0] db_cnt_q;
  logic [1:0][CW-1:0] db_cnt_d;
  logic [1:0]         lvl_q;
  logic [1:0]         lvl_d;

  // Level follows the synchronized input only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_cnt_d = db_cnt_q;
    lvl_d    = lvl_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          lvl_d[i]    = sync2_q[i];
          db_cnt_d[i] = {CW{1'b0}};
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end else begin
        db_cnt_d[i] = {CW{1'b0}};
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q <= {2{{CW{1'b0}}}};
      lvl_q    <= 2'b00;
    end else begin
      db_cnt_q <= db_cnt_d;
      lvl_q    <= lvl_d;
    end
  end

  assign lvl_s = lvl_q;
`else
  assign lvl_s = sync2_q;
`endif

  // Rising-edge detector; a release (falling level) never yields a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 2'b00;
      pulse_q <= 2'b00;
    end else begin
      prev_q  <= lvl_s;
      pulse_q <= lvl_s & ~prev_q;
    end
  end

  // Clear beats load; guarded steps saturate so an illegal FSM command cannot wrap the count.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = MIN_C;
    end else if (ld) begin
      if (!s) begin
        if (count_q < MAX_C) begin
          count_d = count_q + ONE_C;
        end else begin
          count_d = count_q;
        end
      end else begin
        if (count_q > MIN_C) begin
          count_d = count_q - ONE_C;
        end else begin
          count_d = count_q;
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= MIN_C;
    end else begin
      count_q <= count_d;
    end
  end

  assign U     = pulse_q[0];
  assign D     = pulse_q[1];
  assign count = count_q;
  assign CM    = (count_q < MAX_C);
  assign Cm    = (count_q > MIN_C);

endmodule

// File: tb/tb_counter_datapath.sv
// Directed bench for counter_datapath: reset, button pulses, count commands, limits and priority.
// With DEBOUNCE_EN defined it also exercises the bounce/glitch filtering at DB_CYCLES=16.
module tb_counter_datapath;

  localparam int WIDTH     = 4;
  localparam int MAX_VAL   = 9;
  localparam int MIN_VAL   = 0;
  localparam int DB_CYCLES = 16;
`ifdef DEBOUNCE_EN
  localparam int PULSE_EDGE = DB_CYCLES + 3;
`else
  localparam int PULSE_EDGE = 3;
`endif
  localparam int IDLE = 25;

  logic             clk = 1'b0;
  logic             rst;
  logic             btn_up;
  logic             btn_dn;
  logic             ld;
  logic             clr;
  logic             s;
  logic             U;
  logic             D;
  logic             CM;
  logic             Cm;
  logic [WIDTH-1:0] count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  counter_datapath #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .MIN_VAL  (MIN_VAL),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_up(btn_up),
    .btn_dn(btn_dn),
    .ld    (ld),
    .clr   (clr),
    .s     (s),
    .U     (U),
    .D     (D),
    .CM    (CM),
    .Cm    (Cm),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0; ld = 1'b0; clr = 1'b0; s = 1'b0;
    idle_ticks(3);
    check("rst_count", 32'(count), 32'd0);
    check("rst_U", 32'(U), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_CM", 32'(CM), 32'd1);
    check("rst_Cm", 32'(Cm), 32'd0);
    rst = 1'b0;
    tick();

    // Count up to the ceiling, then one more load must hold.
    ld = 1'b1; s = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("up_count", 32'(count), 32'(k));
    end
    check("top_CM", 32'(CM), 32'd0);
    check("top_Cm", 32'(Cm), 32'd1);
    tick();
    check("sat_top", 32'(count), 32'd9);
    s = 1'b1;
    tick();
    check("dn_from_top", 32'(count), 32'd8);
    check("dn_CM", 32'(CM), 32'd1);
    idle_ticks(3);
    ld = 1'b0;
    tick();
    check("hold_5", 32'(count), 32'd5);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_CM", 32'(CM), 32'd1);
    check("async_Cm", 32'(Cm), 32'd0);
    check("async_U", 32'(U), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Decrement at the floor holds; clear outranks load.
    ld = 1'b1; s = 1'b1;
    tick();
    check("sat_bot", 32'(count), 32'd0);
    check("bot_Cm", 32'(Cm), 32'd0);
    s = 1'b0;
    idle_ticks(7);
    check("up_to_7", 32'(count), 32'd7);
    clr = 1'b1;
    tick();
    check("clr_prio", 32'(count), 32'd0);
    ld = 1'b0; clr = 1'b0;
    tick();
    check("idle_hold", 32'(count), 32'd0);

    // Single up press held well past the pulse: one U only, D stays quiet.
    btn_up = 1'b1;
    for (int k = 1; k <= PULSE_EDGE + 7; k++) begin
      tick();
      check("up_U", 32'(U), 32'(k == PULSE_EDGE));
      check("up_D", 32'(D), 32'd0);
    end
    btn_up = 1'b0;
    for (int k = 1; k <= IDLE; k++) begin
      tick();
      check("release_U", 32'(U), 32'd0);
    end

`ifdef DEBOUNCE_EN
    // A 15-cycle glitch stays one short of the stability threshold.
    btn_up = 1'b1;
    idle_ticks(15);
    btn_up = 1'b0;
    for (int k = 1; k <= IDLE + 15; k++) begin
      tick();
      check("glitch_U", 32'(U), 32'd0);
    end
    // Bounce every 3 cycles, then a steady level.
    for (int c = 0; c < 30; c++) begin
      btn_up = ((c / 3) % 2 == 0);
      tick();
      check("bounce_U", 32'(U), 32'd0);
    end
    btn_up = 1'b1;
    for (int k = 1; k <= PULSE_EDGE + 5; k++) begin
      tick();
      check("steady_U", 32'(U), 32'(k == PULSE_EDGE));
    end
    btn_up = 1'b0;
    idle_ticks(IDLE);
`endif

    // Simultaneous presses pulse together; a reset mid-hold restarts the edge detector.
    btn_up = 1'b1; btn_dn = 1'b1;
    for (int k = 1; k <= PULSE_EDGE + 2; k++) begin
      tick();
      check("sim_U", 32'(U), 32'(k == PULSE_EDGE));
      check("sim_D", 32'(D), 32'(k == PULSE_EDGE));
    end
    rst = 1'b1;
    idle_ticks(2);
    check("midrst_U", 32'(U), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= PULSE_EDGE + 3; k++) begin
      tick();
      check("fresh_U", 32'(U), 32'(k == PULSE_EDGE));
      check("fresh_D", 32'(D), 32'(k == PULSE_EDGE));
    end
    btn_up = 1'b0; btn_dn = 1'b0;
    idle_ticks(IDLE);
    check("end_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
